// File: rtl/store_rmw_unit_pkg.sv
// Shared definitions for the store path: access-size codes, FSM state encoding
// and the alignment rule that the load extender also uses.
package store_rmw_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ERR   = 3'd1;
    localparam state_t ST_WR    = 3'd2;
    localparam state_t ST_RD    = 3'd3;
    localparam state_t ST_WAIT  = 3'd4;
    localparam state_t ST_MERGE = 3'd5;

    // Illegal size codes count as misaligned so callers need only one test.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = offset[0];
            SIZE_WORD: is_misaligned = |offset;
            default:   is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: places narrow store data into its little-endian
// lane(s) of the old memory word and reports which byte lanes were replaced.
module store_lane_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  byte_off,
    output logic [31:0] merged,
    output logic [3:0]  lane_mask
);

    logic [31:0] lane_data;

    // Replicating the narrow value across the word lets every lane pick from the same bits.
    always_comb begin
        lane_mask = 4'b0000;
        lane_data = new_data;
        case (size)
            SIZE_BYTE: begin
                lane_mask = 4'b0001 << byte_off;
                lane_data = {4{new_data[7:0]}};
            end
            SIZE_HALF: begin
                lane_mask = byte_off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{new_data[15:0]}};
            end
            SIZE_WORD: lane_mask = 4'b1111;
            default:   lane_mask = 4'b0000;
        endcase
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (lane_mask[k]) merged[8*k +: 8] = lane_data[8*k +: 8];
        end
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store narrowing unit: word stores go straight to memory, sub-word stores
// read the word, merge the new lanes and write it back; bad accesses are rejected.
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic              st_done,
    output logic              st_err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata
);

    localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    state_t            state;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [1:0]        lat_size;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       merged;
    logic [3:0]        lane_mask;
    logic              accept;

    assign accept   = req_valid & req_ready;
    assign mem_addr = lat_addr[ADDR_W-1:2];

    store_lane_merge u_merge (
        .old_word  (mem_rdata),
        .new_data  (lat_wdata),
        .size      (lat_size),
        .byte_off  (lat_addr[1:0]),
        .merged    (merged),
        .lane_mask (lane_mask)
    );

    // Strobes are registered at the transition that enters each state, so the
    // state register always names what the outputs are doing this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= 32'h0;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
            lat_size  <= 2'b00;
            cnt       <= '0;
        end else begin
            st_done   <= 1'b0;
            st_err    <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_size  <= req_size;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            state   <= ST_ERR;
                            st_done <= 1'b1;
                            st_err  <= 1'b1;
                        end else if (req_size == SIZE_WORD) begin
                            state     <= ST_WR;
                            mem_wr_en <= 1'b1;
                            mem_wdata <= req_wdata;
                            st_done   <= 1'b1;
                        end else begin
                            state     <= ST_RD;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                ST_ERR, ST_WR, ST_MERGE: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                ST_RD: begin
                    state <= ST_WAIT;
                    cnt   <= CNT_INIT;
                end
                // Read data is merged on the cycle it arrives; no separate holding register.
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state     <= ST_MERGE;
                        mem_wr_en <= |lane_mask;
                        mem_wdata <= merged;
                        st_done   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
